// File: rtl/cmd_decoder_pkg.sv
// Shared definitions for the command stream decoder and its encoder peer.
// Holds the frame PREFIX, destination count, error codes, FSM state type,
// per-packet context struct and the data-count helper.
package cmd_decoder_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned N_SRC  = 4;
  localparam int unsigned SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [BYTE_W-1:0] PREFIX = 8'hA5;

  // err_code values, valid only alongside pkt_err
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_SRC = 2'd1;
  localparam logic [1:0] ERR_CRC     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GET_SOURCE = 3'd1,
    ST_GET_LEN    = 3'd2,
    ST_GET_DATA   = 3'd3,
    ST_GET_CRC    = 3'd4
  } state_e;

  // Per-packet context latched while a frame is being parsed
  typedef struct packed {
    logic [SRC_W-1:0]  dest;
    logic [BYTE_W-1:0] len;
    logic [BYTE_W-1:0] cnt;
  } pkt_ctx_t;

  // A len of 0 still carries one data byte
  function automatic logic [BYTE_W-1:0] data_count(input logic [BYTE_W-1:0] len);
    return (len == '0) ? BYTE_W'(1) : len;
  endfunction

endpackage

// File: rtl/cmd_decoder_if.sv
// Byte-stream input and destination-side bus of the command decoder.
//   rx_data/rx_valid/rx_ready : upstream byte stream, transfer on valid & ready
//   dst_full_bus              : per-destination sink full
//   dst_wrreq_bus/dst_data    : one-hot write strobe plus shared payload byte
//   pkt_done_bus              : good-packet pulse on the addressed destination
//   pkt_err/err_code          : abort pulse and its cause
// master: stream source and sinks; slave: the decoder.
interface cmd_decoder_if;
  import cmd_decoder_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [N_SRC-1:0]  dst_full_bus;
  logic [N_SRC-1:0]  dst_wrreq_bus;
  logic [BYTE_W-1:0] dst_data;
  logic [N_SRC-1:0]  pkt_done_bus;
  logic              pkt_err;
  logic [1:0]        err_code;

  modport master (
    output rx_data, rx_valid, dst_full_bus,
    input  rx_ready, dst_wrreq_bus, dst_data, pkt_done_bus, pkt_err, err_code
  );

  modport slave (
    input  rx_data, rx_valid, dst_full_bus,
    output rx_ready, dst_wrreq_bus, dst_data, pkt_done_bus, pkt_err, err_code
  );

endinterface

// File: rtl/cmd_decoder_rx_timeout.sv
// rx_timeout: counts consecutive cycles without clear and flags expiry.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clear    : restart the idle count (byte transfer, or decoder idle)
//   expire_c : high during the LIMIT-th consecutive uncleared cycle
module rx_timeout #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of uncleared cycles already elapsed before this one
  assign expire_c = !clear && (cnt == CNT_W'(LIMIT - 1));

  // Idle-cycle counter, restarted on clear or after firing
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || expire_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cmd_decoder.sv
// cmd_decoder: parses PREFIX/source/len/data/CRC frames from a byte stream
// and steers payload bytes to one of N_SRC destinations.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : cmd_decoder_if.slave (stream in, destination writes, status pulses)
// Parameter TIMEOUT_CYCLES: idle cycles tolerated inside a packet.
// Macro CMD_DECODER_CRC_CHECK_EN: when defined the CRC byte is compared
// against the running sum; otherwise it is consumed and ignored.
module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  cmd_decoder_if.slave  bus
);

  state_e   state;
  pkt_ctx_t ctx;

`ifdef CMD_DECODER_CRC_CHECK_EN
  logic [BYTE_W-1:0] crc;
`endif

  logic dest_full_c;
  logic xfer_c;
  logic tmo_clear_c;
  logic tmo_expire_c;

  // Ready is a function of state and the live sink flag so a full sink
  // stalls the stream in the same cycle rather than one cycle late.
  assign dest_full_c  = bus.dst_full_bus[ctx.dest];
  assign bus.rx_ready = !rst && !((state == ST_GET_DATA) && dest_full_c);
  assign xfer_c       = bus.rx_valid && bus.rx_ready;

  // Timeout only runs inside a packet; any transfer restarts it
  assign tmo_clear_c = (state == ST_IDLE) || xfer_c;

  rx_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmo_clear_c),
    .expire_c (tmo_expire_c)
  );

  // Frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      ctx               <= '0;
`ifdef CMD_DECODER_CRC_CHECK_EN
      crc               <= '0;
`endif
      bus.dst_wrreq_bus <= '0;
      bus.dst_data      <= '0;
      bus.pkt_done_bus  <= '0;
      bus.pkt_err       <= 1'b0;
      bus.err_code      <= ERR_NONE;
    end else begin
      bus.dst_wrreq_bus <= '0;
      bus.pkt_done_bus  <= '0;
      bus.pkt_err       <= 1'b0;
      bus.err_code      <= ERR_NONE;

      // expire_c is only raised in cycles without a transfer
      if (tmo_expire_c) begin
        state        <= ST_IDLE;
        bus.pkt_err  <= 1'b1;
        bus.err_code <= ERR_TIMEOUT;
      end else if (xfer_c) begin
        unique case (state)
          ST_IDLE: begin
            if (bus.rx_data == PREFIX) begin
              state <= ST_GET_SOURCE;
            end
          end

          ST_GET_SOURCE: begin
            if (bus.rx_data < BYTE_W'(N_SRC)) begin
              ctx.dest <= SRC_W'(bus.rx_data);
              state    <= ST_GET_LEN;
            end else begin
              bus.pkt_err  <= 1'b1;
              bus.err_code <= ERR_BAD_SRC;
              state        <= ST_IDLE;
            end
          end

          ST_GET_LEN: begin
            ctx.len <= bus.rx_data;
            ctx.cnt <= '0;
`ifdef CMD_DECODER_CRC_CHECK_EN
            crc     <= '0;
`endif
            state   <= ST_GET_DATA;
          end

          // PREFIX values here are plain payload, never a resync
          ST_GET_DATA: begin
            bus.dst_data      <= bus.rx_data;
            bus.dst_wrreq_bus <= N_SRC'(1) << ctx.dest;
`ifdef CMD_DECODER_CRC_CHECK_EN
            crc               <= crc + bus.rx_data;
`endif
            ctx.cnt           <= ctx.cnt + BYTE_W'(1);
            if ((ctx.cnt + BYTE_W'(1)) == data_count(ctx.len)) begin
              state <= ST_GET_CRC;
            end
          end

          ST_GET_CRC: begin
`ifdef CMD_DECODER_CRC_CHECK_EN
            if (bus.rx_data == crc) begin
              bus.pkt_done_bus <= N_SRC'(1) << ctx.dest;
            end else begin
              bus.pkt_err  <= 1'b1;
              bus.err_code <= ERR_CRC;
            end
`else
            bus.pkt_done_bus <= N_SRC'(1) << ctx.dest;
`endif
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Self-checking bench for cmd_decoder: directed frames plus randomized
// frames, checked against an event-list model built from the frame rules.
module tb_cmd_decoder;
  import cmd_decoder_pkg::*;

  localparam int unsigned TMO = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_decoder_if bus ();

  cmd_decoder #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observed events (monitor only) and expected events (main only)
  int obs[$];
  int exp_q[$];
  int rd = 0;
  int inv_viol = 0;

  logic [7:0]       pl[$];
  logic [N_SRC-1:0] bg_full = '0;

  // event word: kind 0 = write, 1 = done, 2 = error
  function automatic int ev(input int kind, input int d, input int v);
    return (kind << 16) | (d << 8) | v;
  endfunction

  function automatic int bit_idx(input logic [N_SRC-1:0] v);
    for (int i = 0; i < int'(N_SRC); i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitor: record every output event and count exclusivity violations
  always @(negedge clk) begin
    if (bus.dst_wrreq_bus != '0)
      obs.push_back(ev(0, bit_idx(bus.dst_wrreq_bus), int'(bus.dst_data)));
    if (bus.pkt_done_bus != '0)
      obs.push_back(ev(1, bit_idx(bus.pkt_done_bus), 0));
    if (bus.pkt_err === 1'b1)
      obs.push_back(ev(2, 0, int'(bus.err_code)));
    if (!$onehot0(bus.dst_wrreq_bus) || !$onehot0(bus.pkt_done_bus) ||
        (bus.pkt_err && (bus.pkt_done_bus != '0)))
      inv_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    #1;
    while (!bus.rx_ready && w < 2000) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 2000) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_bound observed=%0d expected<2000 waits", w);
    end else begin
      @(posedge clk);
    end
  endtask

  // Present a data byte while the destination is full for n cycles
  task automatic send_stalled(input logic [7:0] b, input int dest, input int n);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.dst_full_bus[dest] = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("stall_ready", 32'(bus.rx_ready), 32'd0);
      @(negedge clk);
    end
    bus.dst_full_bus[dest] = 1'b0;
    #1;
    chk("ready_release", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    bus.rx_valid     = 1'b0;
    bus.dst_full_bus = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_events(input string tag);
    int n_obs;
    repeat (4) @(negedge clk);
    #1;
    n_obs = obs.size() - rd;
    chk({tag, "_count"}, 32'(n_obs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_obs; i++)
      chk(tag, 32'(obs[rd + i]), 32'(exp_q[i]));
    rd = obs.size();
    exp_q.delete();
  endtask

  // Good-source frame from pl; crc_xor != 0 corrupts the CRC byte
  task automatic run_good(input string tag, input int src, input logic [7:0] len,
                          input logic [7:0] crc_xor, input int stall_at, input int stall_n);
    int sum;
    sum = 0;
    bus.dst_full_bus = bg_full & ~(N_SRC'(1) << src);
    send_byte(PREFIX);
    send_byte(8'(src));
    send_byte(len);
    for (int i = 0; i < pl.size(); i++) begin
      exp_q.push_back(ev(0, src, int'(pl[i])));
      sum = sum + int'(pl[i]);
      if (i == stall_at) send_stalled(pl[i], src, stall_n);
      else send_byte(pl[i]);
    end
    send_byte(8'(sum) ^ crc_xor);
`ifdef CMD_DECODER_CRC_CHECK_EN
    if (crc_xor == 8'd0) exp_q.push_back(ev(1, src, 0));
    else exp_q.push_back(ev(2, 0, 2));
`else
    exp_q.push_back(ev(1, src, 0));
`endif
    go_idle(1);
    check_events(tag);
  endtask

  task automatic fill_payload(input int len);
    int n;
    n = (len == 0) ? 1 : len;
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst              = 1'b1;
    bus.rx_data      = '0;
    bus.rx_valid     = 1'b0;
    bus.dst_full_bus = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_wrreq", 32'(bus.dst_wrreq_bus), 32'd0);
    chk("rst_data", 32'(bus.dst_data), 32'd0);
    chk("rst_done", 32'(bus.pkt_done_bus), 32'd0);
    chk("rst_err", 32'(bus.pkt_err), 32'd0);
    chk("rst_code", 32'(bus.err_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.rx_ready), 32'd1);

    // A5 02 03 10 20 30 60
    pl = '{8'h10, 8'h20, 8'h30};
    run_good("frame_a", 2, 8'd3, 8'd0, -1, 0);

    // A5 01 00 7F 7F
    pl = '{8'h7F};
    run_good("frame_len0", 1, 8'd0, 8'd0, -1, 0);

    // A5 07 -> bad source, then a frame with PREFIX bytes in payload
    send_byte(PREFIX);
    send_byte(8'h07);
    exp_q.push_back(ev(2, 0, 1));
    go_idle(1);
    check_events("bad_src");
    pl = '{PREFIX, 8'h01};
    run_good("after_bad_src", 3, 8'd2, 8'd0, -1, 0);

    // A5 00 02 01 02 FF (real sum 03)
    pl = '{8'h01, 8'h02};
    run_good("crc_bad", 0, 8'd2, 8'hFC, -1, 0);

    // Destination 3 full for 5 cycles mid-payload
    fill_payload(6);
    run_good("stall", 3, 8'd6, 8'd0, 2, 5);

    // Stream stops after len -> timeout, then junk, then a good frame
    send_byte(PREFIX);
    send_byte(8'h01);
    send_byte(8'h04);
    exp_q.push_back(ev(2, 0, 3));
    go_idle(TMO + 20);
    check_events("timeout");
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h5A);
    go_idle(1);
    check_events("junk");
    pl = '{8'hC3};
    run_good("after_timeout", 2, 8'd1, 8'd0, -1, 0);

    // Gap well below the limit mid-packet must not abort
    send_byte(PREFIX);
    send_byte(8'h00);
    send_byte(8'h01);
    go_idle(TMO - 30);
    send_byte(8'h44);
    send_byte(8'h44);
    exp_q.push_back(ev(0, 0, 8'h44));
    exp_q.push_back(ev(1, 0, 0));
    go_idle(1);
    check_events("gap_ok");

    // Maximum length with CRC wrap
    fill_payload(255);
    run_good("len255", 1, 8'd255, 8'd0, 100, 3);

    // Reset mid-packet: written byte stays, no done/err
    send_byte(PREFIX);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h10);
    exp_q.push_back(ev(0, 1, 8'h10));
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_events("mid_reset");
    pl = '{8'h99, 8'h01};
    run_good("after_mid_reset", 1, 8'd2, 8'd0, -1, 0);

    // Randomized frames with junk, background full on other sinks, stalls
    for (int f = 0; f < 30; f++) begin
      int kind;
      int src;
      int len;
      kind = int'($urandom_range(0, 9));
      bg_full = N_SRC'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        send_byte(8'($urandom_range(0, 15)));
        go_idle(1);
      end
      if (kind == 0) begin
        src = int'($urandom_range(4, 255));
        send_byte(PREFIX);
        send_byte(8'(src));
        exp_q.push_back(ev(2, 0, 1));
        go_idle(1);
        check_events("rnd_bad_src");
      end else begin
        src = int'($urandom_range(0, N_SRC - 1));
        len = int'($urandom_range(0, 12));
        fill_payload(len);
        run_good("rnd_frame", src, 8'(len),
                 (kind == 1) ? 8'($urandom_range(1, 255)) : 8'd0,
                 int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
      end
    end
    bg_full = '0;

    chk("exclusive_outputs", 32'(inv_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
